// File: rtl/rfid_pkg.sv
// rfid_pkg: shared state encoding, LED colour constants and default master UID
package rfid_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_GRANT,
      S_DENY,
      S_ENR_WAIT,
      S_ENR_WRITE,
      S_RELEASE,
      S_LOCK
   } state_t;

   // LED colour as {R,G,B}
   typedef logic [2:0] rgb_t;

   localparam rgb_t RGB_OFF   = 3'b000;
   localparam rgb_t RGB_RED   = 3'b100;
   localparam rgb_t RGB_GREEN = 3'b010;
   localparam rgb_t RGB_BLUE  = 3'b001;
   localparam rgb_t RGB_CYAN  = 3'b011;

   localparam logic [31:0] DEFAULT_MASTER_UID = 32'hDEADBEEF;

   // Status LED colour for a state
   function automatic rgb_t rgb1_of(input state_t s);
      return s == S_IDLE  ? RGB_BLUE  :
             s == S_GRANT ? RGB_GREEN :
             s == S_DENY  ? RGB_RED   : RGB_OFF;
   endfunction

   // Mode LED colour for a state; LOCK is only reachable in lockout builds
   function automatic rgb_t rgb2_of(input state_t s);
      return (s == S_ENR_WAIT || s == S_ENR_WRITE) ? RGB_CYAN :
             s == S_LOCK ? RGB_RED : RGB_OFF;
   endfunction

endpackage

// File: rtl/rfid_access_ctrl_uid_table.sv
// uid_table: register-based allow table with round-robin write pointer and parallel lookup
module uid_table
   import rfid_pkg::*;
#(
   parameter int unsigned N_ENTRIES = 4
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en_i,
   input  logic [31:0] wr_uid_i,
   input  logic [31:0] lookup_i,
   output logic        hit_o
);

   localparam int PW = $clog2(N_ENTRIES);

   logic [31:0]          entry_q [N_ENTRIES];
   logic [N_ENTRIES-1:0] vld_q;
   logic [PW-1:0]        ptr_q;

   // Valid bits and write pointer; pointer wraps so the oldest entry is replaced
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= '0;
         ptr_q <= '0;
      end else if (wr_en_i) begin
         vld_q[ptr_q] <= 1'b1;
         ptr_q        <= ptr_q + PW'(1);
      end
   end

   // Entry data needs no reset since it is qualified by the valid bits
   always_ff @(posedge clk) begin
      if (wr_en_i) entry_q[ptr_q] <= wr_uid_i;
   end

   // Parallel compare against all valid entries
   always_comb begin
      hit_o = 1'b0;
      for (int i = 0; i < N_ENTRIES; i++) hit_o = hit_o | (vld_q[i] && entry_q[i] == lookup_i);
   end

endmodule

// File: rtl/rfid_access_ctrl.sv
// rfid_access_ctrl: card access sequencer with allow table, timed grant/deny LEDs and master enrollment; lockout enabled by RFID_LOCKOUT_EN
module rfid_access_ctrl
   import rfid_pkg::*;
#(
   parameter int unsigned N_ENTRIES     = 4,
   parameter logic [31:0] MASTER_UID    = DEFAULT_MASTER_UID,
   parameter int unsigned GRANT_CYCLES  = 50_000_000,
   parameter int unsigned DENY_CYCLES   = 25_000_000,
   parameter int unsigned ENROLL_CYCLES = 250_000_000,
   parameter int unsigned LOCK_CYCLES   = 500_000_000
)(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] uid,
   input  logic        card_ok,
   output logic        grant,
   output logic        deny,
   output logic        enrolled,
   output logic        busy,
   output logic        RGB1_R,
   output logic        RGB1_G,
   output logic        RGB1_B,
   output logic        RGB2_R,
   output logic        RGB2_G,
   output logic        RGB2_B
);

   // One shared down-counter sized for the longest timer
   localparam int unsigned MAX_GD = GRANT_CYCLES > DENY_CYCLES ? GRANT_CYCLES : DENY_CYCLES;
   localparam int unsigned MAX_EL = ENROLL_CYCLES > LOCK_CYCLES ? ENROLL_CYCLES : LOCK_CYCLES;
   localparam int unsigned MAX_C  = MAX_GD > MAX_EL ? MAX_GD : MAX_EL;
   localparam int          CW     = $clog2(MAX_C + 1);
   localparam logic [CW-1:0] G_LD = CW'(GRANT_CYCLES - 1);
   localparam logic [CW-1:0] D_LD = CW'(DENY_CYCLES - 1);
   localparam logic [CW-1:0] E_LD = CW'(ENROLL_CYCLES - 1);
`ifdef RFID_LOCKOUT_EN
   localparam logic [CW-1:0] L_LD = CW'(LOCK_CYCLES - 1);
   logic [1:0] fail_q, fail_d;
`endif

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ret_q, ret_d;
   logic          ok_prev_q;
   logic [31:0]   uid_q;
   logic          grant_q, deny_q, enrolled_q, busy_q;
   rgb_t          rgb1_q, rgb2_q;
   logic          ev, hit;
   logic [31:0]   lookup;

   assign ev     = card_ok && !ok_prev_q;
   assign lookup = state_q == S_ENR_WAIT ? uid : uid_q;

   uid_table #(.N_ENTRIES(N_ENTRIES)) u_table (
      .clk      (clk),
      .rst      (rst),
      .wr_en_i  (state_q == S_ENR_WRITE),
      .wr_uid_i (uid_q),
      .lookup_i (lookup),
      .hit_o    (hit)
   );

   // Next-state, timer and master-return decisions
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ret_d   = ret_q;
`ifdef RFID_LOCKOUT_EN
      fail_d  = fail_q;
`endif
      case (state_q)
         S_IDLE: state_d = ev ? S_CHECK : S_IDLE;
         S_CHECK: begin
            if (uid_q == MASTER_UID) begin
               state_d = S_RELEASE;
               ret_d   = 1'b1;
            end else if (hit) begin
               state_d = S_GRANT;
               cnt_d   = G_LD;
`ifdef RFID_LOCKOUT_EN
               fail_d  = 2'd0;
`endif
            end else begin
               state_d = S_DENY;
               cnt_d   = D_LD;
`ifdef RFID_LOCKOUT_EN
               fail_d  = fail_q + 2'd1;
`endif
            end
         end
         S_GRANT: begin
            state_d = cnt_q == '0 ? S_RELEASE : S_GRANT;
            cnt_d   = cnt_q - CW'(1);
         end
         S_DENY: begin
`ifdef RFID_LOCKOUT_EN
            state_d = cnt_q != '0 ? S_DENY : fail_q == 2'd3 ? S_LOCK : S_RELEASE;
            cnt_d   = cnt_q == '0 ? L_LD : cnt_q - CW'(1);
`else
            state_d = cnt_q == '0 ? S_RELEASE : S_DENY;
            cnt_d   = cnt_q - CW'(1);
`endif
         end
         S_ENR_WAIT: begin
            state_d = ev ? ((uid == MASTER_UID || hit) ? S_RELEASE : S_ENR_WRITE) :
                      cnt_q == '0 ? S_IDLE : S_ENR_WAIT;
            cnt_d   = cnt_q - CW'(1);
         end
         S_ENR_WRITE: begin
            state_d = S_GRANT;
            cnt_d   = G_LD;
`ifdef RFID_LOCKOUT_EN
            fail_d  = 2'd0;
`endif
         end
         S_RELEASE: begin
            state_d = card_ok ? S_RELEASE : ret_q ? S_ENR_WAIT : S_IDLE;
            cnt_d   = E_LD;
            ret_d   = card_ok && ret_q;
         end
`ifdef RFID_LOCKOUT_EN
         S_LOCK: begin
            state_d = cnt_q == '0 ? S_RELEASE : S_LOCK;
            cnt_d   = cnt_q - CW'(1);
            fail_d  = cnt_q == '0 ? 2'd0 : fail_q;
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   // State, timers, edge history, captured UID and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         ret_q      <= 1'b0;
         ok_prev_q  <= 1'b0;
         uid_q      <= '0;
         grant_q    <= 1'b0;
         deny_q     <= 1'b0;
         enrolled_q <= 1'b0;
         busy_q     <= 1'b0;
         rgb1_q     <= RGB_OFF;
         rgb2_q     <= RGB_OFF;
`ifdef RFID_LOCKOUT_EN
         fail_q     <= 2'd0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ret_q      <= ret_d;
         ok_prev_q  <= card_ok;
         uid_q      <= ev ? uid : uid_q;
         grant_q    <= state_d == S_GRANT;
         deny_q     <= state_d == S_DENY;
         enrolled_q <= state_q == S_ENR_WRITE;
         busy_q     <= state_d != S_IDLE;
         rgb1_q     <= rgb1_of(state_d);
         rgb2_q     <= rgb2_of(state_d);
`ifdef RFID_LOCKOUT_EN
         fail_q     <= fail_d;
`endif
      end
   end

   assign grant    = grant_q;
   assign deny     = deny_q;
   assign enrolled = enrolled_q;
   assign busy     = busy_q;
   assign {RGB1_R, RGB1_G, RGB1_B} = rgb1_q;
   assign {RGB2_R, RGB2_G, RGB2_B} = rgb2_q;

endmodule

// File: tb/tb_rfid_access_ctrl.sv
// tb_rfid_access_ctrl: directed checks of lookup, grant/deny timing, enrollment, hold/release and optional lockout
module tb_rfid_access_ctrl;

   localparam logic [31:0] MASTER = 32'hDEADBEEF;
   localparam logic [31:0] CARD_A = 32'h12345678;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] uid = '0;
   logic        card_ok = 1'b0;
   logic        grant, deny, enrolled, busy;
   logic        RGB1_R, RGB1_G, RGB1_B, RGB2_R, RGB2_G, RGB2_B;
   int          n_tests = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   rfid_access_ctrl #(
      .N_ENTRIES     (4),
      .MASTER_UID    (MASTER),
      .GRANT_CYCLES  (8),
      .DENY_CYCLES   (4),
      .ENROLL_CYCLES (32),
      .LOCK_CYCLES   (16)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .uid      (uid),
      .card_ok  (card_ok),
      .grant    (grant),
      .deny     (deny),
      .enrolled (enrolled),
      .busy     (busy),
      .RGB1_R   (RGB1_R),
      .RGB1_G   (RGB1_G),
      .RGB1_B   (RGB1_B),
      .RGB2_R   (RGB2_R),
      .RGB2_G   (RGB2_G),
      .RGB2_B   (RGB2_B)
   );

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Raise card_ok with a UID; returns one cycle later (the CHECK cycle)
   task automatic present(input logic [31:0] u);
      uid = u;
      card_ok = 1'b1;
      tick(1);
   endtask

   // Full grant sequence from the CHECK cycle: 8 cycles high starting at t+2, then release
   task automatic do_grant(input string tag, input logic [31:0] u);
      present(u);
      chk({tag, "_g_t1"}, grant, 1'b0);
      tick(1);
      chk({tag, "_g_t2"}, grant, 1'b1);
      chk({tag, "_rgb1"}, {RGB1_R, RGB1_G, RGB1_B}, 3'b010);
      tick(7);
      chk({tag, "_g_last"}, grant, 1'b1);
      tick(1);
      chk({tag, "_g_end"}, grant, 1'b0);
      card_ok = 1'b0;
      tick(1);
      chk({tag, "_idle"}, busy, 1'b0);
   endtask

   // Full deny sequence: 4 cycles high starting at t+2, then release
   task automatic do_deny(input string tag, input logic [31:0] u);
      present(u);
      chk({tag, "_d_t1"}, deny, 1'b0);
      tick(1);
      chk({tag, "_d_t2"}, deny, 1'b1);
      chk({tag, "_rgb1"}, {RGB1_R, RGB1_G, RGB1_B}, 3'b100);
      tick(3);
      chk({tag, "_d_last"}, deny, 1'b1);
      tick(1);
      chk({tag, "_d_end"}, deny, 1'b0);
      card_ok = 1'b0;
      tick(1);
      chk({tag, "_idle"}, busy, 1'b0);
   endtask

   // Master card, release, then new card: enrolled pulse with grant rising together
   task automatic enroll(input string tag, input logic [31:0] u);
      present(MASTER);
      card_ok = 1'b0;
      tick(2);
      chk({tag, "_rgb2"}, {RGB2_R, RGB2_G, RGB2_B}, 3'b011);
      present(u);
      tick(1);
      chk({tag, "_enr"}, enrolled, 1'b1);
      chk({tag, "_g_first"}, grant, 1'b1);
      tick(1);
      chk({tag, "_enr_off"}, enrolled, 1'b0);
      tick(6);
      chk({tag, "_g_last"}, grant, 1'b1);
      tick(1);
      chk({tag, "_g_end"}, grant, 1'b0);
      card_ok = 1'b0;
      tick(1);
      chk({tag, "_idle"}, busy, 1'b0);
   endtask

   initial begin
      // Reset: every output low while reset is held
      tick(3);
      chk("rst_outs", {grant, deny, enrolled, busy}, 4'b0000);
      chk("rst_leds", {RGB1_R, RGB1_G, RGB1_B, RGB2_R, RGB2_G, RGB2_B}, 6'b000000);
      rst = 1'b0;
      tick(1);
      chk("idle_rgb1", {RGB1_R, RGB1_G, RGB1_B}, 3'b001);
      chk("idle_busy", busy, 1'b0);

      // Unknown card is denied; busy during CHECK
      present(CARD_A);
      chk("chk_busy", busy, 1'b1);
      card_ok = 1'b1;
      tick(1);
      chk("deny_t2", deny, 1'b1);
      chk("deny_rgb1", {RGB1_R, RGB1_G, RGB1_B}, 3'b100);
      tick(3);
      chk("deny_last", deny, 1'b1);
      tick(1);
      chk("deny_end", deny, 1'b0);
      chk("deny_rel_busy", busy, 1'b1);
      card_ok = 1'b0;
      tick(1);
      chk("deny_idle", busy, 1'b0);

      // Enrol CARD_A then re-present it
      enroll("enrA", CARD_A);
      do_grant("reA", CARD_A);

      // Reset mid-grant aborts and clears the table
      present(CARD_A);
      tick(1);
      chk("mid_grant", grant, 1'b1);
      rst = 1'b1;
      tick(1);
      chk("mid_rst_grant", grant, 1'b0);
      chk("mid_rst_busy", busy, 1'b0);
      rst = 1'b0;
      card_ok = 1'b0;
      tick(1);
      do_deny("cleared", CARD_A);

      // Five enrolments into four entries: first is overwritten
      enroll("e1", 32'h0000_0001);
      enroll("e2", 32'h0000_0002);
      enroll("e3", 32'h0000_0003);
      enroll("e4", 32'h0000_0004);
      enroll("e5", 32'h0000_0005);
      do_deny("u1_gone", 32'h0000_0001);
      do_grant("u2", 32'h0000_0002);
      do_grant("u3", 32'h0000_0003);
      do_grant("u4", 32'h0000_0004);
      do_grant("u5", 32'h0000_0005);

      // Card held across the grant: single grant, UID change ignored
      present(32'h0000_0002);
      tick(1);
      chk("hold_g", grant, 1'b1);
      tick(8);
      chk("hold_g_end", grant, 1'b0);
      uid = 32'h0000_0003;
      tick(5);
      chk("hold_no_regrant", grant, 1'b0);
      chk("hold_busy", busy, 1'b1);
      card_ok = 1'b0;
      tick(1);
      chk("hold_idle", busy, 1'b0);
      do_grant("hold_again", 32'h0000_0002);

      // Enrollment window times out after 32 idle cycles
      present(MASTER);
      card_ok = 1'b0;
      tick(2);
      chk("to_rgb2_on", {RGB2_R, RGB2_G, RGB2_B}, 3'b011);
      tick(31);
      chk("to_rgb2_last", {RGB2_R, RGB2_G, RGB2_B}, 3'b011);
      tick(1);
      chk("to_rgb2_off", {RGB2_R, RGB2_G, RGB2_B}, 3'b000);
      chk("to_idle", busy, 1'b0);

      // Master twice cancels without a write
      present(MASTER);
      card_ok = 1'b0;
      tick(2);
      present(MASTER);
      tick(1);
      chk("cancel_enr", enrolled, 1'b0);
      chk("cancel_grant", grant, 1'b0);
      chk("cancel_rgb2", {RGB2_R, RGB2_G, RGB2_B}, 3'b000);
      chk("cancel_busy", busy, 1'b1);
      card_ok = 1'b0;
      tick(1);
      chk("cancel_idle", busy, 1'b0);
      do_deny("master_not_stored", 32'h0000_0001);

      // Enrolling a card already present: no write, no grant
      present(MASTER);
      card_ok = 1'b0;
      tick(2);
      present(32'h0000_0003);
      tick(1);
      chk("dup_enr", enrolled, 1'b0);
      chk("dup_grant", grant, 1'b0);
      card_ok = 1'b0;
      tick(1);
      chk("dup_idle", busy, 1'b0);
      do_grant("dup_still", 32'h0000_0003);

`ifdef RFID_LOCKOUT_EN
      // Third consecutive deny enters a 16-cycle lockout that ignores known cards
      do_deny("lk1", 32'hAAAA_0001);
      do_deny("lk2", 32'hAAAA_0002);
      present(32'hAAAA_0003);
      tick(1);
      chk("lk3_deny", deny, 1'b1);
      tick(4);
      chk("lk_deny_end", deny, 1'b0);
      chk("lk_rgb2", {RGB2_R, RGB2_G, RGB2_B}, 3'b100);
      card_ok = 1'b0;
      tick(1);
      present(32'h0000_0003);
      card_ok = 1'b0;
      tick(13);
      chk("lk_rgb2_last", {RGB2_R, RGB2_G, RGB2_B}, 3'b100);
      chk("lk_no_grant", grant, 1'b0);
      tick(1);
      chk("lk_exit_rgb2", {RGB2_R, RGB2_G, RGB2_B}, 3'b000);
      chk("lk_exit_grant", grant, 1'b0);
      tick(1);
      chk("lk_idle", busy, 1'b0);
      do_grant("lk_after", 32'h0000_0003);
`else
      // Without lockout, a third consecutive deny just releases
      do_deny("nl1", 32'hAAAA_0001);
      do_deny("nl2", 32'hAAAA_0002);
      do_deny("nl3", 32'hAAAA_0003);
      chk("nl_rgb2", {RGB2_R, RGB2_G, RGB2_B}, 3'b000);
      do_grant("nl_after", 32'h0000_0003);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rfid_access_ctrl.md
# rfid_access_ctrl

Access-control sequencer that sits downstream of the rc522 reader core and consumes its `UID`/`card_OK` outputs. On each new card detection it looks up the 32-bit UID in a small register-based allow table. It then drives timed grant/deny indications on the two RGB LEDs, and supports master-card enrollment of new UIDs. It replaces direct LED drive by the reader core.

## Interface
- `N_ENTRIES`, 4 — allow-table depth (power of two, 2..16).
- `MASTER_UID`, 32'hDEADBEEF — hard-wired enrollment card; never stored in the table.
- `GRANT_CYCLES`, 50_000_000 — grant indication duration.
- `DENY_CYCLES`, 25_000_000 — deny indication duration.
- `ENROLL_CYCLES`, 250_000_000 — enrollment window timeout.
- `LOCK_CYCLES`, 500_000_000 — lockout duration (macro only).
- `clk` in 1 — system clock.
- `rst` in 1 — reset, synchronous, active-high.
- `uid` in 32 — UID from reader; valid while `card_ok` high.
- `card_ok` in 1 — level, high while a valid card is read.
- `grant` out 1 — high for the whole GRANT state.
- `deny` out 1 — high for the whole DENY state.
- `enrolled` out 1 — one-cycle pulse when a table write occurs.
- `busy` out 1 — high in any state other than IDLE.
- `RGB1_R`, `RGB1_G`, `RGB1_B` out 1 each — status LED, active-high.
- `RGB2_R`, `RGB2_G`, `RGB2_B` out 1 each — mode LED, active-high.

## Operation
- Event is the rising edge of `card_ok`, using a registered previous value. `uid` is captured into `uid_q` on the event cycle.
- States:
  - IDLE: wait for an event.
  - CHECK: one-cycle lookup of `uid_q`.
  - GRANT: counting.
  - DENY: counting.
  - ENR_WAIT: waiting for the card to enroll.
  - ENR_WRITE: one cycle.
  - RELEASE: wait for `card_ok` low.
  - LOCK: macro only.
- Transitions from CHECK:
  - `uid_q==MASTER_UID` → RELEASE, then ENR_WAIT.
  - Hit in any valid entry → GRANT.
  - Otherwise → DENY.
- GRANT/DENY run a down-counter loaded with `*_CYCLES-1`. At zero they go to RELEASE.
- RELEASE returns to IDLE, or to ENR_WAIT if it was entered from a master detection, on the first cycle `card_ok` is low. A card held in the field therefore never retriggers.
- ENR_WAIT, on event:
  - Master UID → cancel to RELEASE, then IDLE.
  - UID already in the table → RELEASE, no write, no `enrolled` pulse.
  - Otherwise → ENR_WRITE.
- ENR_WAIT with no event for `ENROLL_CYCLES` → IDLE.
- ENR_WRITE:
  - Writes `uid_q` at `wr_ptr` and sets its valid bit.
  - Pulses `enrolled`.
  - Increments `wr_ptr` modulo `N_ENTRIES`. When the table is full, the oldest entry is overwritten.
  - Next state is GRANT.
- Lookup is combinational over all entries, ANDed with the valid bit. Multiple hits are impossible by construction.
- LEDs:
  - RGB1 = IDLE blue, GRANT green, DENY red, all other states off.
  - RGB2 = ENR_WAIT/ENR_WRITE green+blue, LOCK red, otherwise off.
- Reset:
  - All outputs 0.
  - State IDLE, all valid bits 0, `wr_ptr` 0, counters 0.
  - `card_ok` history cleared to 0, so a card present at reset release produces an event.
- Reset mid-operation aborts to IDLE with the table cleared.

## Timing
- The event is detected in cycle t, when `card_ok` is high and its registered value is low.
- CHECK occurs at t+1.
- `grant`/`deny` first go high at t+2. Both are registered outputs.
- `grant` stays high exactly `GRANT_CYCLES` cycles; `deny` stays high exactly `DENY_CYCLES` cycles.
- `enrolled` is high in the cycle after ENR_WRITE, and `grant` rises in that same cycle.
- A `card_ok` event during GRANT, DENY or RELEASE is ignored; it is not queued.
- `uid` changes while `card_ok` stays high are ignored.

## Configuration
- `RFID_LOCKOUT_EN` defined:
  - A 2-bit failure counter increments on each DENY and clears on GRANT.
  - Reaching 3 sends DENY → LOCK instead of RELEASE. LOCK lasts `LOCK_CYCLES` and ignores all events, including master.
  - On exit, LOCK clears the counter and goes to RELEASE.
- Undefined: no counter, no LOCK state, `LOCK_CYCLES` unused, and RGB2 red is never lit.

## Structure
- Shared package `rfid_pkg`:
  - State enum.
  - LED colour constants.
  - Default `MASTER_UID`.
- One sub-module `uid_table`:
  - Entry registers, valid bits and `wr_ptr`.
  - Write port.
  - Combinational `hit` output.
  - Parameterised by `N_ENTRIES`.
- The FSM and timers live in the top of this block.
- Benches override `*_CYCLES` to small values (e.g. 8/4/32/16).

## Test plan
- Reset, then `card_ok` rises with `uid=32'h12345678` → `deny` high at t+2 for 4 cycles, RGB1_R lit.
- Master card, release, then card `32'h12345678` → `enrolled` pulse, `grant` for 8 cycles. Re-presenting that card after release → `grant` again.
- Enroll 5 distinct UIDs with `N_ENTRIES=4` → first UID now denied, UIDs 2–5 granted.
- Hold the card across the whole GRANT period → single grant. No second grant until `card_ok` has been low for at least one cycle.
- Master card, then no card for 32 cycles → back to IDLE, RGB2 off. Master twice → cancel, no write.
- With `RFID_LOCKOUT_EN`: three unknown cards → third DENY enters LOCK for 16 cycles with RGB2_R lit. An enrolled card during LOCK → no grant.
